// File: rtl/fifo_umbral_pkg.sv
// Shared defaults for the flow-control FIFOs; the FSM and the probador import the
// same values so threshold widths agree across the transmission layer.
package fifo_umbral_pkg;
    localparam int DEF_DATA_WIDTH = 6;
    localparam int DEF_ADDR_WIDTH = 3;
    localparam int DEF_U_WIDTH    = 4;
    localparam int UMBRAL_RST     = 1;
endpackage

// File: rtl/fifo_umbral_memoria_dp.sv
// DEPTH x DATA_WIDTH register file: one synchronous write port, one registered read port.
// The array itself is never reset; only the read register is.
module memoria_dp
    import fifo_umbral_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Reading the slot being overwritten returns the old word, which is the oldest entry.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
endmodule

// File: rtl/fifo_umbral.sv
// Synchronous FIFO with programmable almost-full/almost-empty threshold and a sticky
// overflow/underflow error flag, one instance per flow-control FIFO.
module fifo_umbral
    import fifo_umbral_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int U_WIDTH    = DEF_U_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic [U_WIDTH-1:0]    umbral,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  error
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;
    localparam int EW    = (U_WIDTH > CW) ? U_WIDTH : CW;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d, umbral_eff;
    logic [U_WIDTH-1:0]    umbral_q, umbral_d;
    logic [EW-1:0]         umbral_ext;
    logic                  data_valid_q, data_valid_d;
    logic                  error_q, error_d;
    logic                  push_ok, pop_ok;

    // A push into a full FIFO is legal only when a pop frees a slot in the same cycle.
    always_comb begin
        push_ok      = push && (!full || pop);
        pop_ok       = pop && !empty;
        wr_ptr_d     = push_ok ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
        rd_ptr_d     = pop_ok  ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
        data_valid_d = pop_ok;
        umbral_d     = init ? umbral : umbral_q;
        error_d      = error_q || (push && full && !pop) || (pop && empty);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            umbral_q     <= U_WIDTH'(UMBRAL_RST);
            data_valid_q <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            umbral_q     <= umbral_d;
            data_valid_q <= data_valid_d;
            error_q      <= error_d;
        end
    end

    // Thresholds above the depth saturate so the flags stay meaningful.
    always_comb begin
        umbral_ext = EW'(umbral_q);
        umbral_eff = (umbral_ext > EW'(DEPTH)) ? DEPTH_C : CW'(umbral_ext);
    end

    assign count        = count_q;
    assign empty        = (count_q == '0);
    assign full         = (count_q == DEPTH_C);
    assign almost_full  = (count_q >= (DEPTH_C - umbral_eff));
    assign almost_empty = (count_q <= umbral_eff);
    assign data_valid   = data_valid_q;
    assign error        = error_q;

    memoria_dp #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (push_ok),
        .wr_addr(wr_ptr_q),
        .wr_data(data_in),
        .rd_en  (pop_ok),
        .rd_addr(rd_ptr_q),
        .rd_data(data_out)
    );
endmodule
